// File: rtl/hazard_scoreboard.sv
// Hazard unit between ID and EX: combinational operand-forward selects plus a
// per-register latency scoreboard that stalls issue on RAW and out-of-order WAW.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int NUM_SRC  = 3,
  parameter int NUM_FWD  = 3,
  parameter int MAX_LAT  = 15,
  parameter int LAT_W    = $clog2(MAX_LAT + 1),
  parameter int SEL_W    = $clog2(NUM_FWD + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [NUM_SRC*5-1:0]     id_rs_addr,
  input  logic [NUM_SRC-1:0]       id_rs_used,
  input  logic                     id_rd_we,
  input  logic [4:0]               id_rd_addr,
  input  logic [LAT_W-1:0]         id_lat,
  output logic                     issue_ready,
  input  logic                     flush_ex,
  input  logic [NUM_SRC*5-1:0]     ex_rs_addr,
  input  logic [NUM_FWD-1:0]       stage_we,
  input  logic [NUM_FWD*5-1:0]     stage_rd,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic [31:0]              stall_cnt
);

  // Issue handshake: an instruction moves ID->EX on a clock edge where
  // id_valid & issue_ready & ~flush_ex; issue_ready never looks at id_valid.

  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic             last_v;
  logic [4:0]       last_rd;
  logic [LAT_W-1:0] last_prev;

  logic             raw_hazard;
  logic             waw_hazard;
  logic             issue;
  logic             load_cnt;
  logic             restore;
  logic [LAT_W-1:0] restore_val;

  // Descending scan so the youngest matching stage is the one left standing.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (ex_rs_addr[5*i +: 5] != 5'd0 && stage_we[k] &&
            stage_rd[5*k +: 5] == ex_rs_addr[5*i +: 5]) begin
          fwd_sel[SEL_W*i +: SEL_W] = SEL_W'(k + 1);
        end
      end
    end
  end

  always_comb begin
    raw_hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i] && id_rs_addr[5*i +: 5] != 5'd0 &&
          cnt[id_rs_addr[5*i +: 5]] != '0) begin
        raw_hazard = 1'b1;
      end
    end
  end

  assign waw_hazard  = id_rd_we && id_rd_addr != 5'd0 && cnt[id_rd_addr] > id_lat;
  assign issue_ready = ~(raw_hazard | waw_hazard);
  assign issue       = id_valid & issue_ready & ~flush_ex;
  assign load_cnt    = issue & id_rd_we & (id_rd_addr != 5'd0) & (id_lat != '0);
  assign restore     = flush_ex & last_v;
  // Two edges have passed since the killed instruction sampled last_prev.
  assign restore_val = (last_prev > LAT_W'(2)) ? last_prev - LAT_W'(2) : '0;

  // cnt[0] is reset and never written again, so x0 never carries a hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      last_v    <= 1'b0;
      last_rd   <= 5'd0;
      last_prev <= '0;
      stall_cnt <= 32'd0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (restore && last_rd == 5'(r)) begin
          cnt[r] <= restore_val;
        end else if (load_cnt && id_rd_addr == 5'(r)) begin
          cnt[r] <= id_lat;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_W'(1);
        end
      end
      last_v <= issue;
      if (issue) begin
        last_rd   <= id_rd_addr;
        last_prev <= cnt[id_rd_addr];
      end
      if (id_valid && !issue_ready && !flush_ex && stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: forwarding vector table, hand-written scoreboard
// sequences, and randomized traffic against a pending-cycles reference model.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [14:0] id_rs_addr;
  logic [2:0]  id_rs_used;
  logic        id_rd_we;
  logic [4:0]  id_rd_addr;
  logic [3:0]  id_lat;
  logic        issue_ready;
  logic        flush_ex;
  logic [14:0] ex_rs_addr;
  logic [2:0]  stage_we;
  logic [14:0] stage_rd;
  logic [5:0]  fwd_sel;
  logic [31:0] stall_cnt;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rs_used(id_rs_used), .id_rd_we(id_rd_we), .id_rd_addr(id_rd_addr),
    .id_lat(id_lat), .issue_ready(issue_ready), .flush_ex(flush_ex),
    .ex_rs_addr(ex_rs_addr), .stage_we(stage_we), .stage_rd(stage_rd),
    .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          pend [32];      // cycles a consumer of register r must still wait
  bit          m_lv;
  int          m_lrd;
  int          m_lprev;
  logic [31:0] m_stalls;
  logic [6:0]  exp_q [$];      // {issue_ready, fwd_sel} expected this cycle
  bit          s_ready;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) pend[r] = 0;
    m_lv = 0; m_lrd = 0; m_lprev = 0; m_stalls = 32'd0;
  endtask

  function automatic bit m_ready();
    bit raw, waw;
    raw = 0;
    for (int i = 0; i < 3; i++) begin
      logic [4:0] a;
      a = id_rs_addr[5*i +: 5];
      if (id_rs_used[i] && a != 0 && pend[a] != 0) raw = 1;
    end
    waw = id_rd_we && id_rd_addr != 0 && pend[id_rd_addr] > int'(id_lat);
    return !(raw || waw);
  endfunction

  function automatic logic [5:0] m_fwd();
    logic [5:0] res;
    res = '0;
    for (int i = 0; i < 3; i++) begin
      logic [4:0] a;
      int sel;
      a = ex_rs_addr[5*i +: 5];
      sel = 0;
      if (a != 0)
        for (int k = 0; k < 3; k++)
          if (sel == 0 && stage_we[k] && stage_rd[5*k +: 5] == a) sel = k + 1;
      res[2*i +: 2] = 2'(sel);
    end
    return res;
  endfunction

  // One clock: compare at negedge, advance model, return at posedge+1.
  task automatic tick();
    logic [6:0] e;
    int pn [32];
    bit iss;
    @(negedge clk);
    exp_q.push_back({m_ready(), m_fwd()});
    e = exp_q.pop_front();
    s_ready = issue_ready;
    check("issue_ready", 32'(issue_ready), 32'(e[6]));
    check("fwd_sel", 32'(fwd_sel), 32'(e[5:0]));
    check("stall_cnt", stall_cnt, m_stalls);
    iss = id_valid && e[6] && !flush_ex;
    for (int r = 0; r < 32; r++) pn[r] = (pend[r] > 0) ? pend[r] - 1 : 0;
    if (flush_ex && m_lv && m_lrd != 0) pn[m_lrd] = (m_lprev > 2) ? m_lprev - 2 : 0;
    if (iss && id_rd_we && id_rd_addr != 0 && id_lat != 0) pn[id_rd_addr] = int'(id_lat);
    if (id_valid && !e[6] && !flush_ex && m_stalls != 32'hFFFF_FFFF) m_stalls++;
    if (iss) begin
      m_lrd = int'(id_rd_addr);
      m_lprev = pend[id_rd_addr];
    end
    m_lv = iss;
    @(posedge clk);
    #1;
    pend = pn;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    id_valid = 0; id_rs_addr = '0; id_rs_used = '0; id_rd_we = 0;
    id_rd_addr = '0; id_lat = '0; flush_ex = 0;
    ex_rs_addr = '0; stage_we = '0; stage_rd = '0;
  endtask

  task automatic drive_id(input bit v, input logic [14:0] rs, input logic [2:0] used,
                          input bit we, input logic [4:0] rd, input logic [3:0] lat);
    id_valid = v; id_rs_addr = rs; id_rs_used = used;
    id_rd_we = we; id_rd_addr = rd; id_lat = lat; flush_ex = 0;
  endtask

  task automatic issue_prod(input logic [4:0] rd, input logic [3:0] lat);
    drive_id(1, '0, '0, 1, rd, lat);
    tick();
    check("producer_accepted", 32'(s_ready), 32'd1);
  endtask

  // Ticks until issue_ready is seen; n counts the stalled cycles before it.
  task automatic count_stalls(output int n);
    bit done;
    n = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (s_ready) done = 1;
      else n++;
    end
    if (!done) check("stall_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    #2;
    check("reset_issue_ready", 32'(issue_ready), 32'd1);
    check("reset_stall_cnt", stall_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // ---------------- forwarding vectors ----------------
  typedef struct {
    logic [14:0] ex;
    logic [2:0]  we;
    logic [14:0] rd;
    logic [5:0]  sel;
  } fwd_vec_t;

  fwd_vec_t vecs [8];

  initial begin
    int n;
    vecs[0] = '{ex: {5'd0, 5'd0, 5'd5}, we: 3'b111, rd: {5'd5, 5'd5, 5'd5}, sel: 6'b00_00_01};
    vecs[1] = '{ex: {5'd0, 5'd0, 5'd5}, we: 3'b110, rd: {5'd5, 5'd5, 5'd5}, sel: 6'b00_00_10};
    vecs[2] = '{ex: {5'd0, 5'd0, 5'd0}, we: 3'b111, rd: {5'd5, 5'd5, 5'd5}, sel: 6'b00_00_00};
    vecs[3] = '{ex: {5'd6, 5'd4, 5'd3}, we: 3'b111, rd: {5'd6, 5'd4, 5'd3}, sel: 6'b11_10_01};
    vecs[4] = '{ex: {5'd3, 5'd2, 5'd1}, we: 3'b111, rd: {5'd9, 5'd8, 5'd7}, sel: 6'b00_00_00};
    vecs[5] = '{ex: {5'd5, 5'd5, 5'd5}, we: 3'b100, rd: {5'd5, 5'd1, 5'd2}, sel: 6'b11_11_11};
    vecs[6] = '{ex: {5'd5, 5'd5, 5'd5}, we: 3'b000, rd: {5'd5, 5'd5, 5'd5}, sel: 6'b00_00_00};
    vecs[7] = '{ex: {5'd0, 5'd0, 5'd0}, we: 3'b001, rd: {5'd0, 5'd0, 5'd0}, sel: 6'b00_00_00};

    idle();
    model_reset();
    do_reset();

    foreach (vecs[i]) begin
      ex_rs_addr = vecs[i].ex; stage_we = vecs[i].we; stage_rd = vecs[i].rd;
      #1;
      check($sformatf("fwd_vec%0d", i), 32'(fwd_sel), 32'(vecs[i].sel));
      tick();
    end
    idle();

    // Load-use: one stall cycle.
    issue_prod(5'd7, 4'd1);
    drive_id(1, {5'd0, 5'd7, 5'd0}, 3'b010, 0, 5'd0, 4'd0);
    tick();
    check("load_use_stall", 32'(s_ready), 32'd0);
    tick();
    check("load_use_go", 32'(s_ready), 32'd1);
    idle();
    check("load_use_stall_cnt", stall_cnt, 32'd1);

    // Multi-cycle producer; unused source must not stall.
    do_reset();
    issue_prod(5'd9, 4'd4);
    drive_id(1, {5'd0, 5'd0, 5'd9}, 3'b001, 0, 5'd0, 4'd0);
    count_stalls(n);
    check("mul_stalls", 32'(n), 32'd4);
    issue_prod(5'd9, 4'd4);
    drive_id(1, {5'd0, 5'd0, 5'd9}, 3'b000, 0, 5'd0, 4'd0);
    tick();
    check("mul_unused_src", 32'(s_ready), 32'd1);

    // WAW: shorter writer waits, longer writer goes straight through.
    issue_prod(5'd3, 4'd5);
    drive_id(1, '0, '0, 1, 5'd3, 4'd1);
    count_stalls(n);
    check("waw_stalls", 32'(n), 32'd4);
    issue_prod(5'd3, 4'd5);
    drive_id(1, '0, '0, 1, 5'd3, 4'd6);
    tick();
    check("waw_longer_accept", 32'(s_ready), 32'd1);
    drive_id(1, {5'd0, 5'd0, 5'd3}, 3'b001, 0, 5'd0, 4'd0);
    count_stalls(n);
    check("waw_new_latency", 32'(n), 32'd6);

    // Flush restores the pre-issue countdown; flush without prior issue is inert.
    issue_prod(5'd4, 4'd6);
    issue_prod(5'd4, 4'd8);
    idle();
    flush_ex = 1;
    tick();
    drive_id(1, {5'd0, 5'd0, 5'd4}, 3'b001, 0, 5'd0, 4'd0);
    count_stalls(n);
    check("flush_restore", 32'(n), 32'd4);
    idle();
    tick();
    issue_prod(5'd4, 4'd3);
    idle();
    tick();
    flush_ex = 1;
    tick();
    drive_id(1, {5'd0, 5'd0, 5'd4}, 3'b001, 0, 5'd0, 4'd0);
    count_stalls(n);
    check("flush_noop", 32'(n), 32'd1);

    // Reset mid-countdown drops the hazard at once.
    issue_prod(5'd10, 4'd12);
    drive_id(1, {5'd0, 5'd0, 5'd10}, 3'b001, 0, 5'd0, 4'd0);
    tick();
    tick();
    do_reset();
    tick();
    check("post_reset_ready", 32'(s_ready), 32'd1);

    // stall_cnt saturation, preloaded just below the limit.
    issue_prod(5'd12, 4'd5);
    idle();
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    m_stalls = 32'hFFFF_FFFE;
    drive_id(1, {5'd0, 5'd0, 5'd12}, 3'b001, 0, 5'd0, 4'd0);
    tick();
    check("stall_cnt_reach_max", stall_cnt, 32'hFFFF_FFFF);
    tick();
    tick();
    check("stall_cnt_hold_max", stall_cnt, 32'hFFFF_FFFF);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      id_valid   = ($urandom_range(0, 9) < 8);
      id_rs_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_rs_used = 3'($urandom_range(0, 7));
      id_rd_we   = 1'($urandom_range(0, 1));
      id_rd_addr = 5'($urandom_range(0, 7));
      id_lat     = 4'($urandom_range(0, 6));
      flush_ex   = ($urandom_range(0, 9) == 0);
      ex_rs_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      stage_we   = 3'($urandom_range(0, 7));
      stage_rd   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
